// File: rtl/sysid_read_arbiter_if.sv
// Bus bundle between the requesting masters, the arbiter and the shared
// system ID slave. The arbiter connects through the slave modport; the
// environment (requesters plus slave model) uses the master modport.
interface sysid_read_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 1,
    parameter int DATA_W  = 32
);
    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]        req_read;
    logic [NUM_REQ*ADDR_W-1:0] req_address;
    logic [NUM_REQ-1:0]        req_waitrequest;
    logic [DATA_W-1:0]         req_readdata;
    logic [ADDR_W-1:0]         slv_address;
    logic [DATA_W-1:0]         slv_readdata;
    logic [GW-1:0]             grant_id;
    logic                      busy;

    modport slave (
        input  req_read, req_address, slv_readdata,
        output req_waitrequest, req_readdata, slv_address, grant_id, busy
    );

    modport master (
        output req_read, req_address, slv_readdata,
        input  req_waitrequest, req_readdata, slv_address, grant_id, busy
    );
endinterface

// File: rtl/sysid_read_arbiter.sv
// Round-robin read arbiter in front of a single read-only system ID slave.
// One read in flight at a time; the slave's fixed latency is absorbed by a
// down-counter, and the granted requester sees a one-cycle waitrequest-low
// pulse with the captured data. All outputs come straight from registers.
module sysid_read_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int ADDR_W        = 1,
    parameter int DATA_W        = 32,
    parameter int SLAVE_LATENCY = 0
) (
    input  logic                 clock,
    input  logic                 reset_n,
    sysid_read_arbiter_if.slave  bus
);
    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = (SLAVE_LATENCY > 0) ? $clog2(SLAVE_LATENCY + 1) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(SLAVE_LATENCY);
    localparam logic [GW-1:0] LAST_INIT = GW'(NUM_REQ - 1);

    typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

    state_t              state_q, state_d;
    logic [GW-1:0]       last_q, last_d;
    logic [GW-1:0]       grant_q, grant_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [NUM_REQ-1:0]  wreq_q, wreq_d;
    logic                busy_q, busy_d;
    logic [GW-1:0]       pick;

    logic [ADDR_W-1:0]   addr_arr [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_addr
        assign addr_arr[i] = bus.req_address[i*ADDR_W +: ADDR_W];
    end

    // First requester found searching upward from the one after the last grant.
    function automatic logic [GW-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                              input logic [GW-1:0] last);
        logic [GW-1:0] g;
        logic [GW-1:0] ix;
        logic          found;
        int            idx;
        g     = last;
        found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last) + k) % NUM_REQ;
            ix  = GW'(idx);
            if (!found && req[ix]) begin
                g     = ix;
                found = 1'b1;
            end
        end
        return g;
    endfunction

    assign pick = rr_pick(bus.req_read, last_q);

    // State and output registers; reset aborts any transaction in progress.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= IDLE;
            last_q  <= LAST_INIT;
            grant_q <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            rdata_q <= '0;
            wreq_q  <= '1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            rdata_q <= rdata_d;
            wreq_q  <= wreq_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state logic: arbitrate in IDLE, count out latency in WAIT, pulse in ACK.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        grant_d = grant_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        rdata_d = rdata_q;
        wreq_d  = wreq_q;
        busy_d  = busy_q;
        case (state_q)
            IDLE: begin
                wreq_d = '1;
                if (|bus.req_read) begin
                    grant_d = pick;
                    last_d  = pick;
                    addr_d  = addr_arr[pick];
                    busy_d  = 1'b1;
                    cnt_d   = CNT_INIT;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    rdata_d          = bus.slv_readdata;
                    wreq_d           = '1;
                    wreq_d[grant_q]  = 1'b0;
                    state_d          = ACK;
                end
            end
            ACK: begin
                wreq_d  = '1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                wreq_d  = '1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    assign bus.req_waitrequest = wreq_q;
    assign bus.req_readdata    = rdata_q;
    assign bus.slv_address     = addr_q;
    assign bus.grant_id        = grant_q;
    assign bus.busy            = busy_q;
endmodule

// File: tb/tb_sysid_read_arbiter.sv
// Directed bench for sysid_read_arbiter: one instance with a combinational
// slave (latency 0) and one with a three-cycle slave (latency 3).
module tb_sysid_read_arbiter;
    localparam logic [31:0] D0 = 32'hC0DE_0001;
    localparam logic [31:0] D1 = 32'h5A5A_1234;

    logic clock;
    logic rst0_n;
    logic rst3_n;

    int n_checks;
    int n_pass;

    int          acc_n;
    int          acc_id   [8];
    logic [31:0] acc_data [8];
    int          acc_cyc  [8];
    int          max_low;

    sysid_read_arbiter_if #(.NUM_REQ(4), .ADDR_W(1), .DATA_W(32)) bus0 ();
    sysid_read_arbiter_if #(.NUM_REQ(4), .ADDR_W(1), .DATA_W(32)) bus3 ();

    sysid_read_arbiter #(.NUM_REQ(4), .ADDR_W(1), .DATA_W(32), .SLAVE_LATENCY(0)) dut0 (
        .clock   (clock),
        .reset_n (rst0_n),
        .bus     (bus0)
    );

    sysid_read_arbiter #(.NUM_REQ(4), .ADDR_W(1), .DATA_W(32), .SLAVE_LATENCY(3)) dut3 (
        .clock   (clock),
        .reset_n (rst3_n),
        .bus     (bus3)
    );

    function automatic logic [31:0] slave_lut(input logic a);
        return a ? D1 : D0;
    endfunction

    // Latency-0 slave: combinational lookup.
    assign bus0.slv_readdata = slave_lut(bus0.slv_address);

    // Latency-3 slave: lookup delayed through three registers.
    logic [31:0] sd1, sd2, sd3;
    always @(posedge clock) begin
        sd1 <= slave_lut(bus3.slv_address);
        sd2 <= sd1;
        sd3 <= sd2;
    end
    assign bus3.slv_readdata = sd3;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_req(input int which, input logic [3:0] rd, input logic [3:0] ad);
        if (which == 0) begin
            bus0.req_read    = rd;
            bus0.req_address = ad;
        end else begin
            bus3.req_read    = rd;
            bus3.req_address = ad;
        end
    endtask

    // Clock until n waitrequest-low pulses are seen or the budget expires.
    task automatic run_accepts(input int which, input int n, input int budget, input logic auto_drop);
        logic [3:0]  wr;
        logic [3:0]  low;
        logic [31:0] rd;
        acc_n   = 0;
        max_low = 0;
        for (int cyc = 1; cyc <= budget && acc_n < n; cyc++) begin
            tick();
            wr  = (which == 0) ? bus0.req_waitrequest : bus3.req_waitrequest;
            rd  = (which == 0) ? bus0.req_readdata : bus3.req_readdata;
            low = ~wr;
            if ($countones(low) > max_low) max_low = $countones(low);
            if (low != 4'b0) begin
                for (int i = 0; i < 4; i++) begin
                    if (low[i] && acc_n < 8) begin
                        acc_id[acc_n]   = i;
                        acc_data[acc_n] = rd;
                        acc_cyc[acc_n]  = cyc;
                        acc_n++;
                    end
                end
                if (auto_drop) begin
                    if (which == 0) bus0.req_read = bus0.req_read & ~low;
                    else            bus3.req_read = bus3.req_read & ~low;
                end
            end
        end
        check("accepts_seen", 64'(acc_n), 64'(n));
    endtask

    task automatic reset0();
        rst0_n = 1'b0;
        tick();
        rst0_n = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst0_n   = 1'b0;
        rst3_n   = 1'b0;
        set_req(0, 4'b0, 4'b0);
        set_req(1, 4'b0, 4'b0);
        tick();
        tick();

        check("rst_wreq0",  64'(bus0.req_waitrequest), 64'hF);
        check("rst_rdata0", 64'(bus0.req_readdata), 64'h0);
        check("rst_addr0",  64'(bus0.slv_address), 64'h0);
        check("rst_grant0", 64'(bus0.grant_id), 64'h0);
        check("rst_busy0",  64'(bus0.busy), 64'h0);
        check("rst_wreq3",  64'(bus3.req_waitrequest), 64'hF);
        rst0_n = 1'b1;
        rst3_n = 1'b1;

        // Single read, requester 2, address 1, latency 0.
        set_req(0, 4'b0100, 4'b0100);
        tick();
        check("t1_grant",  64'(bus0.grant_id), 64'h2);
        check("t1_busy_a", 64'(bus0.busy), 64'h1);
        check("t1_wreq_a", 64'(bus0.req_waitrequest), 64'hF);
        check("t1_saddr",  64'(bus0.slv_address), 64'h1);
        tick();
        check("t1_wreq_b", 64'(bus0.req_waitrequest), 64'hB);
        check("t1_data",   64'(bus0.req_readdata), 64'(D1));
        check("t1_busy_b", 64'(bus0.busy), 64'h1);
        set_req(0, 4'b0, 4'b0100);
        tick();
        check("t1_wreq_c", 64'(bus0.req_waitrequest), 64'hF);
        check("t1_busy_c", 64'(bus0.busy), 64'h0);
        check("t1_hold",   64'(bus0.req_readdata), 64'(D1));

        // All four at once, addresses 0,1,0,1.
        reset0();
        set_req(0, 4'b1111, 4'b1010);
        run_accepts(0, 4, 30, 1'b1);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t2_id%0d", i),   64'(acc_id[i]), 64'(i));
            check($sformatf("t2_data%0d", i), 64'(acc_data[i]), (i % 2 == 1) ? 64'(D1) : 64'(D0));
            check($sformatf("t2_cyc%0d", i),  64'(acc_cyc[i]), 64'(2 + 3 * i));
        end
        check("t2_onehot", 64'(max_low), 64'h1);

        // After requester 2, requesters 1 and 3 together: 3 first, then 1.
        reset0();
        set_req(0, 4'b0100, 4'b0000);
        run_accepts(0, 1, 10, 1'b1);
        check("t3_first", 64'(acc_id[0]), 64'h2);
        set_req(0, 4'b1010, 4'b0000);
        run_accepts(0, 2, 20, 1'b1);
        check("t3_id0",  64'(acc_id[0]), 64'h3);
        check("t3_id1",  64'(acc_id[1]), 64'h1);
        check("t3_cyc0", 64'(acc_cyc[0]), 64'h3);
        check("t3_cyc1", 64'(acc_cyc[1]), 64'h6);

        // Latency 3: requester 0 holds read for two back-to-back reads.
        set_req(1, 4'b0001, 4'b0000);
        run_accepts(1, 2, 30, 1'b0);
        check("t4_id0",   64'(acc_id[0]), 64'h0);
        check("t4_cyc0",  64'(acc_cyc[0]), 64'h5);
        check("t4_data0", 64'(acc_data[0]), 64'(D0));
        check("t4_cyc1",  64'(acc_cyc[1]), 64'd11);
        check("t4_data1", 64'(acc_data[1]), 64'(D0));

        // Reset in WAIT aborts; pointer restored so requester 0 beats 3.
        set_req(1, 4'b0000, 4'b0000);
        tick();
        set_req(1, 4'b0010, 4'b0000);
        tick();
        check("t5_grant1", 64'(bus3.grant_id), 64'h1);
        check("t5_busy1",  64'(bus3.busy), 64'h1);
        rst3_n = 1'b0;
        set_req(1, 4'b1001, 4'b0000);
        tick();
        check("t5_wreq",  64'(bus3.req_waitrequest), 64'hF);
        check("t5_busy",  64'(bus3.busy), 64'h0);
        check("t5_grant", 64'(bus3.grant_id), 64'h0);
        check("t5_rdata", 64'(bus3.req_readdata), 64'h0);
        rst3_n = 1'b1;
        run_accepts(1, 1, 20, 1'b1);
        check("t5_next_id",  64'(acc_id[0]), 64'h0);
        check("t5_next_cyc", 64'(acc_cyc[0]), 64'h5);
        set_req(1, 4'b0000, 4'b0000);

        // Requester 1 drops read after grant; address change ignored.
        reset0();
        set_req(0, 4'b0010, 4'b0000);
        tick();
        check("t6_grant", 64'(bus0.grant_id), 64'h1);
        set_req(0, 4'b0000, 4'b0010);
        tick();
        check("t6_wreq",  64'(bus0.req_waitrequest), 64'hD);
        check("t6_data",  64'(bus0.req_readdata), 64'(D0));
        tick();
        check("t6_idle",  64'(bus0.req_waitrequest), 64'hF);
        check("t6_busy",  64'(bus0.busy), 64'h0);
        set_req(0, 4'b0100, 4'b0100);
        run_accepts(0, 1, 10, 1'b1);
        check("t6_r2_id",   64'(acc_id[0]), 64'h2);
        check("t6_r2_cyc",  64'(acc_cyc[0]), 64'h2);
        check("t6_r2_data", 64'(acc_data[0]), 64'(D1));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/sysid_read_arbiter.md
Name: sysid_read_arbiter

Overview:
Shares one read-only, word-addressed Avalon-MM control slave (system ID / timestamp style) among NUM_REQ requesting masters. Grants are round-robin, and one read is in flight at a time. The block absorbs the slave's fixed read latency and returns data with a one-cycle waitrequest release. It sits between the HPS/soft-CPU bridges and the system ID slave on the control interconnect.

Parameters:
NUM_REQ, 4, number of requesting masters (2..8)
ADDR_W, 1, slave word-address width
DATA_W, 32, read data width
SLAVE_LATENCY, 0, cycles from slv_address change to valid slv_readdata (0 = combinational slave)

Ports:
clock  input  1  system clock; all logic on rising edge
reset_n  input  1  synchronous active-low reset
req_read  input  NUM_REQ  per-requester read strobe; held until accepted
req_address  input  NUM_REQ*ADDR_W  per-requester word address; requester i uses slice [i*ADDR_W +: ADDR_W]
req_waitrequest  output  NUM_REQ  per-requester stall; low for exactly one cycle = read accepted, data valid
req_readdata  output  DATA_W  shared read data; valid only while the granted requester's waitrequest is low
slv_address  output  ADDR_W  address to shared slave
slv_readdata  input  DATA_W  data from shared slave
grant_id  output  clog2(NUM_REQ)  index of current/last granted requester
busy  output  1  high while a transaction is in flight

Behaviour:
- All outputs are registered.
- Reset, synchronous, dominates everything:
  - req_waitrequest all 1; req_readdata 0; slv_address 0; grant_id 0; busy 0.
  - State IDLE; internal round-robin pointer last = NUM_REQ-1, so requester 0 has first priority.
- FSM states: IDLE, WAIT, ACK.
- IDLE, when req_read is nonzero:
  - Select g = first set bit searching last+1, last+2, ... modulo NUM_REQ.
  - Register grant_id<=g, last<=g, slv_address<=req_address[g], busy<=1, cnt<=SLAVE_LATENCY; go to WAIT.
  - If req_read is zero, remain in IDLE with outputs unchanged except waitrequest all 1.
- WAIT:
  - If cnt!=0, decrement cnt.
  - If cnt==0: req_readdata<=slv_readdata, req_waitrequest[g]<=0 (all other bits stay 1); go to ACK.
- ACK, one cycle only:
  - Granted waitrequest is low and data is valid.
  - Next edge: req_waitrequest[g]<=1, busy<=0; go to IDLE.
  - req_readdata holds its value until the next capture.
- Latency: req_read sampled at edge T gives waitrequest low in cycle T+2+SLAVE_LATENCY. One read completes per SLAVE_LATENCY+3 cycles under continuous demand.
- Arbitration is evaluated only in IDLE. Requests arriving mid-transaction wait, and no requester is granted twice while another is pending.
- Requester drops req_read mid-transaction (protocol violation): the transaction completes normally, the waitrequest-low pulse is still issued, and there is no hang.
- req_address changes after grant have no effect; the address is latched in IDLE.
- cnt width is clog2(SLAVE_LATENCY+1), minimum 1. For SLAVE_LATENCY=0, WAIT lasts exactly one cycle.
- Reset asserted in any state aborts the transaction: no waitrequest-low pulse, and the pointer is restored to NUM_REQ-1.

Test Plan:
- Slave model: addr0 -> 32'hC0DE_0001, addr1 -> 32'h5A5A_1234, SLAVE_LATENCY=0. Requester 2 reads addr1 alone -> waitrequest[2] low exactly at T+2 for one cycle, req_readdata=32'h5A5A_1234, grant_id=2, busy high T+1..T+2.
- All four requesters assert req_read together and hold until accepted, addresses 0,1,0,1 -> accepts in order 0,1,2,3, one every 3 cycles. Data alternates C0DE_0001 / 5A5A_1234, and only one waitrequest bit is low in any cycle.
- After requester 2 is served, requesters 1 and 3 request simultaneously -> 3 granted first, then 1.
- SLAVE_LATENCY=3 with the model delaying data by 3 cycles; requester 0 reads addr0 -> waitrequest[0] low at T+5, data C0DE_0001. A back-to-back second read completes at T+11.
- reset_n driven low for 1 cycle while in WAIT (SLAVE_LATENCY=3) -> next cycle all waitrequest=1, busy=0, grant_id=0, req_readdata=0, no accept pulse. With requesters 0 and 3 still asserting, the next grant goes to 0.
- Requester 1 drops req_read one cycle after grant -> waitrequest[1] still pulses low once, FSM returns to IDLE, and the subsequent request from requester 2 is served normally.
